// File: rtl/gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_vector_sequencer
//  Description : Self-checking stimulus sequencer for the two-input gate leaf
//                (c = ~b, d = a & b). Walks the four {a,b} combinations,
//                waits a settle time, samples the leaf outputs and compares
//                them with the expected values. Reports a saturating error
//                count, a sticky per-vector failure mask and pass/fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_vector_sequencer #(
   parameter int DWELL  = 4,   // settle cycles between drive and sample, 0..255
   parameter int REPEAT = 1,   // full 4-vector passes per run, 1..255
   parameter int ERR_W  = 8    // error counter width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             a_out,
   output logic             b_out,
   input  logic             c_in,
   input  logic             d_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       fail_mask,
   output logic [1:0]       vec_idx
);

   // Counter loads and limits, narrowed once so the FSM compares like widths
   localparam logic [7:0]       DWELL_V   = 8'(DWELL);
   localparam logic [7:0]       LAST_PASS = 8'(REPEAT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t     state;
   logic [7:0] dwell_cnt;
   logic [7:0] pass_cnt;
   logic       mismatch;
   logic       running;

   // Leaf response check against the vector currently held on a_out/b_out;
   // a miss on c, d or both is a single error
   assign mismatch = (c_in != ~b_out) || (d_in != (a_out & b_out));

   // Active part of a run, decoded from the registered state
   assign running = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);
   assign busy    = running;

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_out     <= 1'b0;
         b_out     <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         fail_mask <= 4'b0000;
         vec_idx   <= 2'd0;
         dwell_cnt <= 8'd0;
         pass_cnt  <= 8'd0;
      end else begin
         done <= 1'b0;
         if (running && abort) begin
            // Abort beats everything else, including the final sample;
            // partial error results are left visible
            state   <= S_IDLE;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
            vec_idx <= 2'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state     <= S_DRIVE;
                     err_cnt   <= '0;
                     fail_mask <= 4'b0000;
                     pass      <= 1'b0;
                     vec_idx   <= 2'd0;
                     pass_cnt  <= 8'd0;
                  end
               end
               S_DRIVE: begin
                  a_out     <= vec_idx[1];
                  b_out     <= vec_idx[0];
                  dwell_cnt <= DWELL_V;
                  state     <= (DWELL_V == 8'd0) ? S_SAMPLE : S_SETTLE;
               end
               S_SETTLE: begin
                  // Counter enters at DWELL; leaving at 1 gives DWELL cycles here
                  dwell_cnt <= dwell_cnt - 8'd1;
                  if (dwell_cnt <= 8'd1) begin
                     state <= S_SAMPLE;
                  end
               end
               S_SAMPLE: begin
                  if (mismatch) begin
                     if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + 1'b1;
                     end
                     fail_mask[vec_idx] <= 1'b1;
                  end
                  if (vec_idx != 2'd3) begin
                     vec_idx <= vec_idx + 2'd1;
                     state   <= S_DRIVE;
                  end else if (pass_cnt == LAST_PASS) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     pass_cnt <= pass_cnt + 8'd1;
                     vec_idx  <= 2'd0;
                     state    <= S_DRIVE;
                  end
               end
               S_DONE: begin
                  // err_cnt already includes the final sample here
                  pass  <= (err_cnt == '0);
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_vector_sequencer
//  Description : Bench for gate_vector_sequencer. Two instances (DWELL=4 /
//                REPEAT=1 / ERR_W=8 and DWELL=0 / REPEAT=4 / ERR_W=2) each
//                drive a leaf model with per-vector fault injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_vector_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start0, start1, abort0, abort1;
   logic       a0, b0, c0, d0, busy0, done0, pass0;
   logic       a1, b1, c1, d1, busy1, done1, pass1;
   logic [7:0] err0;
   logic [1:0] err1;
   logic [3:0] mask0, mask1;
   logic [1:0] vec0, vec1;

   // Per-vector corruption of the leaf outputs, indexed by {a,b}
   logic [3:0] fc [2];
   logic [3:0] fd [2];

   int n_tests = 0;
   int n_fail  = 0;

   gate_vector_sequencer #(.DWELL(4), .REPEAT(1), .ERR_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .a_out(a0), .b_out(b0), .c_in(c0), .d_in(d0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_mask(mask0), .vec_idx(vec0));

   gate_vector_sequencer #(.DWELL(0), .REPEAT(4), .ERR_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .a_out(a1), .b_out(b1), .c_in(c1), .d_in(d1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_mask(mask1), .vec_idx(vec1));

   // Leaf models: correct gate function with optional per-vector inversion
   always_comb begin
      c0 = ~b0 ^ fc[0][{a0, b0}];
      d0 = (a0 & b0) ^ fd[0][{a0, b0}];
      c1 = ~b1 ^ fc[1][{a1, b1}];
      d1 = (a1 & b1) ^ fd[1][{a1, b1}];
   end

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic       a;
      logic       b;
      logic [1:0] vec;
      logic [3:0] mask;
      logic [7:0] err;
   } obs_t;

   function automatic obs_t get_obs(input int s);
      obs_t o;
      if (s == 0) o = '{busy0, done0, pass0, a0, b0, vec0, mask0, err0};
      else        o = '{busy1, done1, pass1, a1, b1, vec1, mask1, {6'b0, err1}};
      return o;
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 0) start0 = v; else start1 = v;
   endtask

   task automatic set_abort(input int s, input logic v);
      if (s == 0) abort0 = v; else abort1 = v;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One full run: checks busy/vector trace, done timing, start-ignore and results
   task automatic run_check(input int s, input logic [3:0] cfc, input logic [3:0] cfd,
                            input bit glitch, input logic [7:0] e_err,
                            input logic [3:0] e_mask, input logic e_pass,
                            input string name);
      int   dw, rp, n;
      bit   bad;
      obs_t o;
      dw = (s == 0) ? 4 : 0;
      rp = (s == 0) ? 1 : 4;
      n  = 4 * rp * (dw + 2);
      fc[s] = cfc;
      fd[s] = cfd;
      @(negedge clk);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      bad = 1'b0;
      for (int j = 0; j < n; j++) begin
         o = get_obs(s);
         set_start(s, glitch && (j == n / 2));
         if (!o.busy || o.done || o.vec != 2'((j / (dw + 2)) % 4) ||
             (j > 0 && {o.a, o.b} != 2'(((j - 1) / (dw + 2)) % 4))) begin
            if (!bad) $display("FAIL %s_trace: cycle %0d got busy=%0b done=%0b vec=%0d ab=%0d",
                               name, j, o.busy, o.done, o.vec, {o.a, o.b});
            bad = 1'b1;
         end
         @(negedge clk);
      end
      n_tests++;
      if (bad) n_fail++;
      o = get_obs(s);
      set_start(s, glitch);
      chk({name, "_done"}, {31'd0, o.done}, 32'd1);
      chk({name, "_busy_at_done"}, {31'd0, o.busy}, 32'd0);
      @(negedge clk);
      set_start(s, 1'b0);
      o = get_obs(s);
      chk({name, "_post"}, {30'd0, o.busy, o.done}, 32'd0);
      chk({name, "_err"}, {24'd0, o.err}, {24'd0, e_err});
      chk({name, "_mask"}, {28'd0, o.mask}, {28'd0, e_mask});
      chk({name, "_pass"}, {31'd0, o.pass}, {31'd0, e_pass});
   endtask

   typedef struct {
      int         s;
      logic [3:0] fc;
      logic [3:0] fd;
      bit         glitch;
      logic [7:0] err;
      logic [3:0] mask;
      logic       pass;
   } vec_t;

   vec_t tbl [8];

   initial begin
      obs_t o;
      bit   bad;
      tbl[0] = '{0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 1'b1};  // clean, DWELL=4
      tbl[1] = '{1, 4'b0000, 4'b1000, 1'b0, 8'd3, 4'b1000, 1'b0};  // d stuck 0, 4 passes -> sat 3
      tbl[2] = '{1, 4'b0101, 4'b0000, 1'b0, 8'd3, 4'b0101, 1'b0};  // c stuck 0, 8 raw -> sat 3
      tbl[3] = '{0, 4'b0000, 4'b1000, 1'b0, 8'd1, 4'b1000, 1'b0};  // d stuck 0, one pass
      tbl[4] = '{0, 4'b0101, 4'b0000, 1'b0, 8'd2, 4'b0101, 1'b0};  // c stuck 0, one pass
      tbl[5] = '{0, 4'b0010, 4'b0010, 1'b0, 8'd1, 4'b0010, 1'b0};  // c and d miss together = 1
      tbl[6] = '{1, 4'b0000, 4'b0000, 1'b1, 8'd0, 4'b0000, 1'b1};  // DWELL=0 clean, start while busy
      tbl[7] = '{0, 4'b1111, 4'b1111, 1'b1, 8'd4, 4'b1111, 1'b0};  // all vectors bad

      rst_n = 1'b0;
      start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
      fc[0] = 4'b0; fc[1] = 4'b0; fd[0] = 4'b0; fd[1] = 4'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_a", 32'(get_obs(0)), 32'd0);
      chk("reset_b", 32'(get_obs(1)), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_check(tbl[i].s, tbl[i].fc, tbl[i].fd, tbl[i].glitch,
                   tbl[i].err, tbl[i].mask, tbl[i].pass, $sformatf("vec%0d", i));
      end

      // Abort during SETTLE of vector 2, with vector 0 faulty
      fc[0] = 4'b0001; fd[0] = 4'b0000;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (14) @(negedge clk);
      o = get_obs(0);
      chk("abort_pre", {29'd0, o.busy, o.vec}, {29'd0, 1'b1, 2'd2});
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      o = get_obs(0);
      chk("abort_state", {27'd0, o.busy, o.done, o.a, o.b, o.vec[0] | o.vec[1]}, 32'd0);
      chk("abort_err_held", {24'd0, o.err}, 32'd1);
      chk("abort_mask_held", {28'd0, o.mask}, 32'h1);
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done0 || busy0) bad = 1'b1;
      end
      chk("abort_no_done", {31'd0, bad}, 32'd0);
      chk("abort_pass", {31'd0, pass0}, 32'd0);
      run_check(0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 1'b1, "after_abort");

      // Asynchronous reset in the middle of vector 3 SAMPLE
      fc[0] = 4'b0001;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (23) @(negedge clk);
      o = get_obs(0);
      chk("pre_reset", {21'd0, o.busy, o.a, o.b, o.vec, o.err}, {21'd0, 1'b1, 1'b1, 1'b1, 2'd3, 8'd1});
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_a", 32'(get_obs(0)), 32'd0);
      chk("async_reset_b", 32'(get_obs(1)), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_reset", {31'd0, busy0}, 32'd0);
      run_check(0, 4'b0000, 4'b0000, 1'b0, 8'd0, 4'b0000, 1'b1, "after_reset");

      // Randomized faults against a pass-level reference model
      for (int i = 0; i < 10; i++) begin
         int         s, rp, emax, e;
         logic [3:0] rfc, rfd, m;
         s    = int'($urandom_range(0, 1));
         rfc  = 4'($urandom) & 4'($urandom);
         rfd  = 4'($urandom) & 4'($urandom);
         m    = rfc | rfd;
         rp   = (s == 0) ? 1 : 4;
         emax = (s == 0) ? 255 : 3;
         e    = rp * $countones(m);
         if (e > emax) e = emax;
         run_check(s, rfc, rfd, bit'($urandom_range(0, 1)), 8'(e), m, (m == 4'b0),
                   $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
